// File: rtl/backprop_sequencer.sv
// Walks weight layers top-down and rows 0..size-1, holding each row until step_ready.
// Optional `abort` input is enabled with the BACKPROP_SEQ_ABORT_EN macro.
module backprop_sequencer #(
  parameter int unsigned size        = 3,
  parameter int unsigned layer_count = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cost_mode,
  input  logic        step_ready,
`ifdef BACKPROP_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        is_update,
  output logic [31:0] w_layer_index,
  output logic [31:0] w_row_index,
  output logic        is_cost_layer,
  output logic        backprop_cost,
  output logic        busy,
  output logic        done
);

  localparam int unsigned LW = (layer_count > 1) ? $clog2(layer_count) : 1;
  localparam int unsigned RW = (size > 1) ? $clog2(size) : 1;
  localparam logic [LW-1:0] LAYER_LAST = LW'(layer_count - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(size - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, GAP, DONE} state_t;

  state_t        state;
  logic [LW-1:0] layer;
  logic [RW-1:0] row;
  logic          abort_req;

`ifdef BACKPROP_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      layer         <= '0;
      row           <= '0;
      is_update     <= 1'b0;
      w_layer_index <= '0;
      w_row_index   <= '0;
      is_cost_layer <= 1'b0;
      backprop_cost <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= UPDATE;
            layer         <= LAYER_LAST;
            row           <= '0;
            is_update     <= 1'b1;
            w_layer_index <= 32'(LAYER_LAST);
            w_row_index   <= '0;
            is_cost_layer <= cost_mode;
            backprop_cost <= cost_mode;
            busy          <= 1'b1;
          end
        end
        UPDATE: begin
          if (abort_req) begin
            state         <= IDLE;
            layer         <= '0;
            row           <= '0;
            is_update     <= 1'b0;
            w_layer_index <= '0;
            w_row_index   <= '0;
            is_cost_layer <= 1'b0;
            backprop_cost <= 1'b0;
            busy          <= 1'b0;
          end else if (step_ready) begin
            if (row != ROW_LAST) begin
              row         <= row + 1'b1;
              w_row_index <= 32'(row + 1'b1);
            end else begin
              // Last row of the layer: indices drop to 0 along with is_update.
              row           <= '0;
              is_update     <= 1'b0;
              w_layer_index <= '0;
              w_row_index   <= '0;
              is_cost_layer <= 1'b0;
              if (layer != '0) begin
                state <= GAP;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (abort_req) begin
            state         <= IDLE;
            layer         <= '0;
            row           <= '0;
            is_update     <= 1'b0;
            w_layer_index <= '0;
            w_row_index   <= '0;
            is_cost_layer <= 1'b0;
            backprop_cost <= 1'b0;
            busy          <= 1'b0;
          end else begin
            state         <= UPDATE;
            layer         <= layer - 1'b1;
            row           <= '0;
            is_update     <= 1'b1;
            w_layer_index <= 32'(layer - 1'b1);
            w_row_index   <= '0;
            is_cost_layer <= backprop_cost && ((layer - 1'b1) == LAYER_LAST);
          end
        end
        DONE: begin
          state         <= IDLE;
          layer         <= '0;
          busy          <= 1'b0;
          backprop_cost <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/backprop_sequencer.md
# backprop_sequencer

Sequential driver for the backprop stack controller. On a start pulse it walks the network's weight layers from the top layer down to layer 0, and within each layer walks rows 0..size-1. Each row is held until the downstream stage acknowledges it. It produces the `is_update`, `w_layer_index`, `w_row_index`, `is_cost_layer` and `backprop_cost` qualifiers that the controller decodes into reset, copy and diff-select strobes.

## Interface
- `size`, 3: rows per layer; must match the controller's `size`; ≥1.
- `layer_count`, 3: number of weight layers; ≥1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `cost_mode`  in  1  pass type; latched with `start`; 1 = cost backprop.
- `step_ready`  in  1  downstream has consumed the current row.
- `abort`  in  1  cancel the current pass; present only with `BACKPROP_SEQ_ABORT_EN`.
- `is_update`  out  1  a valid row is presented this cycle.
- `w_layer_index`  out  32  current layer index.
- `w_row_index`  out  32  current row index.
- `is_cost_layer`  out  1  current layer is the cost (top) layer in a cost pass.
- `backprop_cost`  out  1  latched `cost_mode` for the pass.
- `busy`  out  1  sequencer is not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, UPDATE, GAP, DONE. All outputs are registered.
- IDLE:
  - `start`=1 latches `cost_mode` into `backprop_cost`.
  - Next cycle is UPDATE with layer=`layer_count`-1 and row=0.
- UPDATE:
  - `is_update`=1. Layer and row indices are held until `step_ready`=1.
  - `step_ready` with row<size-1: row increments.
  - `step_ready` with row=size-1 and layer>0: go to GAP.
  - `step_ready` with row=size-1 and layer=0: go to DONE.
- GAP:
  - Exactly one cycle with `is_update`=0.
  - Gives the downstream stage a clean boundary before its row-0 reset/copy.
  - Next cycle is UPDATE with layer decremented and row=0.
- DONE:
  - One cycle; `done`=1 and `busy`=1.
  - Next cycle is IDLE; `backprop_cost` is cleared.
- `is_cost_layer` = state==UPDATE && `backprop_cost` && layer==`layer_count`-1.
- Index outputs are 0 whenever `is_update`=0. Internal counters are zero-extended to 32 bits.
- `start` outside IDLE is ignored, and is not queued.
- `step_ready` outside UPDATE is ignored.
- `busy`=1 in UPDATE, GAP and DONE.

## Timing
- Reset values: state=IDLE; every output 0.
- Reset asserted mid-pass returns the block to IDLE immediately. No `done` pulse is produced.
- Latency: `start` at cycle n gives the first `is_update`=1 at cycle n+1.
- Row advance is one cycle after `step_ready` is sampled high. Holding `step_ready` high advances one row per cycle.
- Pass length with `step_ready` tied high: layer_count·size UPDATE cycles + (layer_count-1) GAP cycles + 1 DONE cycle.
- `start` in the DONE cycle is ignored. A new pass is accepted from IDLE at the earliest, one cycle after `done`.
- `size`=1: every UPDATE is both row 0 and the last row.
- `layer_count`=1: no GAP state occurs.

## Configuration
- `BACKPROP_SEQ_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in UPDATE or GAP forces IDLE next cycle, with all outputs 0 and no `done` pulse.
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over `step_ready`.
- `BACKPROP_SEQ_ABORT_EN` undefined: no `abort` port; a pass always runs to DONE.

## Test plan
- Reset with `rst_n`=0 in the middle of UPDATE (layer 1, row 1) → all outputs 0 in the same cycle; state IDLE after release.
- Defaults, `cost_mode`=1, `step_ready`=1, `start` at cycle 0:
  - UPDATE cycles 1–3 (layer 2, rows 0–2) with `is_cost_layer`=1.
  - GAP at cycle 4.
  - Cycles 5–7 layer 1; GAP at cycle 8; cycles 9–11 layer 0.
  - `done` at cycle 12; `busy`=0 at cycle 13.
- `cost_mode`=0 → same sequence as the cost pass, but `is_cost_layer` and `backprop_cost` stay 0 throughout.
- `step_ready` low for 4 cycles at layer 1, row 1 → indices held for 4 cycles; row 2 appears the cycle after `step_ready` rises.
- `start` pulsed during GAP and during DONE → ignored; the pass completes with exactly one `done` pulse.
- Abort, with `BACKPROP_SEQ_ABORT_EN` defined, `abort` at layer 2, row 2 → next cycle `is_update`=0, `busy`=0, no `done`; a new `start` then restarts at layer 2, row 0.
